matrix_operand_sequencer: RTL and testbench
===========================================

Name: matrix_operand_sequencer

Overview:
Operand feeder that drives matrix_mac_unit. It holds two DIM x DIM operand matrices, A and B, loaded through a simple write port. On start it walks every output element C[i][j] in row-major order. For each element it issues one clear cycle, then DIM enabled cycles carrying the operand pairs A[i][k] and B[k][j]. It is the initiator side of the MAC clear/enable/operand interface.

Parameters:
DATA_WIDTH, 8, width of each matrix element and of the mac_a/mac_b outputs.
DIM, 4, matrix dimension (square DIM x DIM), DIM >= 2.
ADDR_W, $clog2(DIM*DIM), load address width (derived, not overridden).
IDX_W, $clog2(DIM), width of the row/column/k indices (derived).

Ports:
clock  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
load_valid  input  1  write one element this cycle.
load_sel  input  1  0 = matrix A, 1 = matrix B.
load_addr  input  ADDR_W  row-major address (row*DIM+col).
load_data  input  DATA_WIDTH  element value.
start  input  1  begin a full multiply sequence.
abort  input  1  synchronous abandon of the current sequence.
busy  output  1  sequence in progress.
done  output  1  one-cycle pulse after the final operand beat.
mac_clear  output  1  clear the MAC accumulator.
mac_enable  output  1  MAC accumulates mac_a*mac_b this cycle.
mac_a  output  DATA_WIDTH  operand A[i][k].
mac_b  output  DATA_WIDTH  operand B[k][j].
mac_last  output  1  final beat (k = DIM-1) of element (i,j).
out_row  output  IDX_W  row i of the element being computed.
out_col  output  IDX_W  column j of the element being computed.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy, done, mac_clear, mac_enable, mac_last = 0; mac_a, mac_b, out_row, out_col = 0; i, j, k counters = 0. Matrix storage is not reset; contents are undefined until loaded.
- All outputs are registered. No combinational path exists from any input to any output.
- Storage: two DIM*DIM arrays. A write with load_valid=1 commits at the clock edge. Writes are accepted only in IDLE; during busy they are ignored. Out-of-range addresses (>= DIM*DIM) are ignored.
- States: IDLE, CLEAR, STREAM, DONE.
- IDLE: all strobes low. start=1 -> CLEAR with i=j=k=0.
  - start and load_valid in the same cycle: the write commits, and the data is visible to the sequence.
  - start while busy: ignored.
- CLEAR (1 cycle): mac_clear=1, mac_enable=0, busy=1, mac_a=mac_b=0, out_row=i, out_col=j. Next state is STREAM.
- STREAM (DIM cycles, k=0..DIM-1): mac_enable=1, mac_a=A[i][k], mac_b=B[k][j], out_row=i, out_col=j, busy=1. mac_last=1 only when k=DIM-1.
  - After k=DIM-1, k wraps to 0 and j increments.
  - When j wraps, i increments.
  - When i and j both wrap, go to DONE; otherwise go to CLEAR.
- DONE (1 cycle): done=1, busy=0, all MAC strobes 0. Next state is IDLE. start is ignored in DONE.
- Timing: with start sampled at edge 0, the first mac_clear is high in cycle 1. Each element takes DIM+1 cycles. The last STREAM beat is in cycle DIM*DIM*(DIM+1). done is high in cycle DIM*DIM*(DIM+1)+1.
- Outside STREAM: mac_enable=0 and mac_a=mac_b=0. Outside CLEAR: mac_clear=0.
- abort=1 in CLEAR or STREAM: next cycle is IDLE, all strobes 0, counters 0, and done is never pulsed. abort in IDLE or DONE has no effect. If abort and start are both asserted in IDLE, start wins.
- Reset mid-sequence: outputs go to their reset values immediately (asynchronously). No done is produced.
- mac_clear and mac_enable are never high in the same cycle.

Test Plan:
- DIM=2. Load A=[[1,2],[3,4]] and B=[[5,6],[7,8]], then pulse start. The pattern must be exactly:
  - (0,0): clear, (1,5), (2,7)last
  - (0,1): clear, (1,6), (2,8)last
  - (1,0): clear, (3,5), (4,7)last
  - (1,1): clear, (3,6), (4,8)last
  - done in cycle 13. A MAC model yields C=[[19,22],[43,50]].
- Back-to-back runs: assert start in the DONE cycle -> it is ignored. Assert start one cycle later -> the identical 12-cycle pattern repeats.
- Load during busy: write A[0]=9 in cycle 3 of a run -> it has no effect. The current run and the next run both still use A[0]=1.
- Abort: assert abort in cycle 5 (the STREAM beat of (0,1)) -> cycle 6 is IDLE, busy=0, mac_enable=0, and done never asserts. A new start then begins at (0,0).
- Async reset: assert reset mid-cycle during STREAM -> busy, mac_enable, mac_a and mac_last read 0 before the next clock edge. After reset release, start with the matrices reloaded gives the correct full sequence.
- Simultaneous start and load: in IDLE, write B[3]=8 with start in the same cycle -> the (1,1) k=1 beat carries mac_b=8.

Source files
------------

// File: rtl/matrix_operand_sequencer.sv
// Purpose: feeds matrix_mac_unit with A[i][k]/B[k][j] pairs, one clear beat per output element.
// Latency: first mac_clear one cycle after start; DIM+1 cycles per element; done one cycle after last beat.
// Backpressure: none; one beat per cycle, start ignored while busy, abort drops back to idle.
module matrix_operand_sequencer #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DIM        = 4,
  localparam int ADDR_W     = $clog2(DIM*DIM),
  localparam int IDX_W      = $clog2(DIM)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic                  load_sel,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  mac_clear,
  output logic                  mac_enable,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic                  mac_last,
  output logic [IDX_W-1:0]      out_row,
  output logic [IDX_W-1:0]      out_col
);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

  state_t                  state;
  logic [IDX_W-1:0]        row_idx;
  logic [IDX_W-1:0]        col_idx;
  logic [IDX_W-1:0]        k_idx;
  logic [IDX_W-1:0]        row_inc;
  logic [IDX_W-1:0]        col_inc;
  logic [IDX_W-1:0]        k_inc;
  logic                    addr_ok;

  logic [DATA_WIDTH-1:0]   mem_a [DIM*DIM];
  logic [DATA_WIDTH-1:0]   mem_b [DIM*DIM];

  // Row-major flat address of element (r, c).
  function automatic logic [ADDR_W-1:0] idx(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(DIM) + ADDR_W'(c);
  endfunction

  // The row/column being worked on are the counters themselves, already registered.
  assign out_row = row_idx;
  assign out_col = col_idx;

  // Incremented indices; only used where the current index is below DIM-1.
  always_comb begin
    row_inc = row_idx + IDX_W'(1);
    col_inc = col_idx + IDX_W'(1);
    k_inc   = k_idx + IDX_W'(1);
    addr_ok = (32'(load_addr) < 32'(DIM*DIM));
  end

  // Operand storage: writes only land while idle, so a running sequence sees stable matrices.
  always_ff @(posedge clock) begin
    if (load_valid && (state == IDLE) && addr_ok) begin
      if (load_sel) mem_b[load_addr] <= load_data;
      else          mem_a[load_addr] <= load_data;
    end
  end

  // Sequencer FSM: walks C[i][j] row-major, one clear beat then DIM operand beats per element.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mac_clear  <= 1'b0;
      mac_enable <= 1'b0;
      mac_last   <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
      row_idx    <= '0;
      col_idx    <= '0;
      k_idx      <= '0;
    end else begin
      // Strobes and operands are single-beat; each state re-asserts what it needs.
      done       <= 1'b0;
      mac_clear  <= 1'b0;
      mac_enable <= 1'b0;
      mac_last   <= 1'b0;
      mac_a      <= '0;
      mac_b      <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            mac_clear <= 1'b1;
            row_idx   <= '0;
            col_idx   <= '0;
            k_idx     <= '0;
          end
        end
        CLEAR: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            row_idx <= '0;
            col_idx <= '0;
            k_idx   <= '0;
          end else begin
            state      <= STREAM;
            mac_enable <= 1'b1;
            mac_a      <= mem_a[idx(row_idx, '0)];
            mac_b      <= mem_b[idx('0, col_idx)];
            k_idx      <= '0;
          end
        end
        STREAM: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            row_idx <= '0;
            col_idx <= '0;
            k_idx   <= '0;
          end else if (k_idx == IDX_LAST) begin
            k_idx <= '0;
            if ((row_idx == IDX_LAST) && (col_idx == IDX_LAST)) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              row_idx <= '0;
              col_idx <= '0;
            end else begin
              state     <= CLEAR;
              mac_clear <= 1'b1;
              if (col_idx == IDX_LAST) begin
                col_idx <= '0;
                row_idx <= row_inc;
              end else begin
                col_idx <= col_inc;
              end
            end
          end else begin
            k_idx      <= k_inc;
            mac_enable <= 1'b1;
            mac_a      <= mem_a[idx(row_idx, k_inc)];
            mac_b      <= mem_b[idx(k_inc, col_idx)];
            mac_last   <= (k_inc == IDX_LAST);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Bench for matrix_operand_sequencer at DIM=2: expected beat traces are built from the
// matrix-product definition and a MAC accumulator rebuilds C from the observed beats.
module tb_matrix_operand_sequencer;

  localparam int DIM  = 2;
  localparam int DW   = 8;
  localparam int IW   = $clog2(DIM);
  localparam int AW   = $clog2(DIM*DIM);
  localparam int NCYC = DIM*DIM*(DIM+1) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid, load_sel, start, abort;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          busy, done, mac_clear, mac_enable, mac_last;
  logic [DW-1:0] mac_a, mac_b;
  logic [IW-1:0] out_row, out_col;

  always #5 clock = ~clock;

  matrix_operand_sequencer #(.DATA_WIDTH(DW), .DIM(DIM)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .start(start), .abort(abort),
    .busy(busy), .done(done), .mac_clear(mac_clear), .mac_enable(mac_enable),
    .mac_a(mac_a), .mac_b(mac_b), .mac_last(mac_last),
    .out_row(out_row), .out_col(out_col)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          clr;
    logic          en;
    logic          last;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } beat_t;

  beat_t obs_now;
  assign obs_now = {busy, done, mac_clear, mac_enable, mac_last, out_row, out_col, mac_a, mac_b};

  int vectors     = 0;
  int miscompares = 0;
  int ma [DIM][DIM];
  int mb [DIM][DIM];
  int c_obs [DIM][DIM];

  function automatic beat_t mk(input bit bz, input bit dn, input bit cl, input bit en,
                               input bit ls, input int r, input int c, input int a, input int b);
    beat_t t;
    t.busy = bz; t.done = dn; t.clr = cl; t.en = en; t.last = ls;
    t.row = IW'(r); t.col = IW'(c); t.a = DW'(a); t.b = DW'(b);
    return t;
  endfunction

  task automatic clear_inputs();
    load_valid = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic load_elem(input bit sel, input int addr, input int data);
    @(negedge clock);
    clear_inputs();
    load_valid = 1'b1; load_sel = sel; load_addr = AW'(addr); load_data = DW'(data);
  endtask

  task automatic load_model();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        load_elem(1'b0, i*DIM + j, ma[i][j]);
        load_elem(1'b1, i*DIM + j, mb[i][j]);
      end
    @(negedge clock);
    clear_inputs();
  endtask

  // One full sequence: cycle 0 carries start, cycles 1..NCYC+1 are checked beat by beat.
  task automatic run_seq(input string name, input int abort_cyc, input int load_cyc,
                         input bit lsel, input int laddr, input int ldata,
                         input bit start_in_done, input bit chain, input bit skip_start);
    beat_t exp_b [64];
    beat_t o;
    int    c;
    int    acc;
    int    ref_c;
    c = 1;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        exp_b[c] = mk(1, 0, 1, 0, 0, i, j, 0, 0);
        c++;
        for (int k = 0; k < DIM; k++) begin
          exp_b[c] = mk(1, 0, 0, 1, (k == DIM-1), i, j, ma[i][k], mb[k][j]);
          c++;
        end
      end
    exp_b[c]     = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
    exp_b[c + 1] = '0;
    if (abort_cyc > 0)
      for (int x = abort_cyc + 1; x <= NCYC + 1; x++) exp_b[x] = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) c_obs[i][j] = -1;
    acc = 0;

    if (!skip_start) begin
      @(negedge clock);
      clear_inputs();
      start = 1'b1;
      if (load_cyc == 0) begin
        load_valid = 1'b1; load_sel = lsel; load_addr = AW'(laddr); load_data = DW'(ldata);
      end
    end

    for (int cy = 1; cy <= NCYC + 1; cy++) begin
      @(negedge clock);
      o = obs_now;
      if (!exp_b[cy].busy) begin
        o.row = '0;
        o.col = '0;
      end
      vectors++;
      if (o !== exp_b[cy]) begin
        miscompares++;
        $display("FAIL %s cycle %0d: observed %h expected %h", name, cy, o, exp_b[cy]);
      end
      if (obs_now.clr) acc = 0;
      if (obs_now.en) begin
        acc += int'(obs_now.a) * int'(obs_now.b);
        if (obs_now.last) c_obs[int'(obs_now.row)][int'(obs_now.col)] = acc;
      end
      clear_inputs();
      if (start_in_done && cy == NCYC) start = 1'b1;
      if (chain && cy == NCYC + 1)     start = 1'b1;
      if (cy == load_cyc) begin
        load_valid = 1'b1; load_sel = lsel; load_addr = AW'(laddr); load_data = DW'(ldata);
      end
      if (cy == abort_cyc) abort = 1'b1;
    end

    if (abort_cyc == 0) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          ref_c = 0;
          for (int k = 0; k < DIM; k++) ref_c += ma[i][k] * mb[k][j];
          vectors++;
          if (c_obs[i][j] !== ref_c) begin
            miscompares++;
            $display("FAIL %s C[%0d][%0d]: observed %0d expected %0d", name, i, j, c_obs[i][j], ref_c);
          end
        end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (obs_now !== beat_t'(0)) begin
      miscompares++;
      $display("FAIL reset_outputs: observed %h expected 0", obs_now);
    end
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if (obs_now !== beat_t'(0)) begin
      miscompares++;
      $display("FAIL idle_after_reset: observed %h expected 0", obs_now);
    end
  endtask

  task automatic test_directed();
    int cexp [DIM][DIM];
    ma   = '{'{1, 2}, '{3, 4}};
    mb   = '{'{5, 6}, '{7, 8}};
    cexp = '{'{19, 22}, '{43, 50}};
    load_model();
    run_seq("directed", 0, -1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        vectors++;
        if (c_obs[i][j] !== cexp[i][j]) begin
          miscompares++;
          $display("FAIL directed_C[%0d][%0d]: observed %0d expected %0d", i, j, c_obs[i][j], cexp[i][j]);
        end
      end
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_first", 0, -1, 0, 0, 0, 1, 1, 0);
    run_seq("b2b_second", 0, -1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_load_during_busy();
    run_seq("load_busy_run", 0, 3, 0, 0, 9, 0, 0, 0);
    run_seq("load_busy_next", 0, -1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    run_seq("abort", 5, -1, 0, 0, 0, 0, 0, 0);
    run_seq("after_abort", 0, -1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_start_with_load();
    load_elem(1'b1, 3, 8'h55);
    mb[1][1] = 8;
    run_seq("start_with_load", 0, 0, 1, 3, 8, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    beat_t e;
    @(negedge clock);
    clear_inputs();
    start = 1'b1;
    for (int cy = 1; cy <= 3; cy++) begin
      @(negedge clock);
      clear_inputs();
    end
    e = mk(1, 0, 0, 1, 1, 0, 0, ma[0][1], mb[1][0]);
    vectors++;
    if (obs_now !== e) begin
      miscompares++;
      $display("FAIL async_reset_pre: observed %h expected %h", obs_now, e);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (obs_now !== beat_t'(0)) begin
      miscompares++;
      $display("FAIL async_reset_immediate: observed %h expected 0", obs_now);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = $urandom_range(0, 255);
        mb[i][j] = $urandom_range(0, 255);
      end
    load_model();
    run_seq("after_async_reset", 0, -1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          ma[i][j] = $urandom_range(0, 255);
          mb[i][j] = $urandom_range(0, 255);
        end
      load_model();
      run_seq("random", 0, -1, 0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_load_during_busy();
    test_abort();
    test_start_with_load();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
